// File: rtl/enigma_rotor_stack.sv
// Bank of modular rotor position counters with notch-driven carry, synchronous load and
// rising-edge step detection. Define ENIGMA_DOUBLE_STEP_EN for pawl (double-step) advance.
module enigma_rotor_stack #(
    parameter int NUM_ROTORS = 3,
    parameter int MODULUS    = 26,
    parameter int WIDTH      = 5,
    parameter logic [NUM_ROTORS*WIDTH-1:0] NOTCH = {5'd21, 5'd4, 5'd16}
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        step_req,
    input  logic                        load,
    input  logic [NUM_ROTORS*WIDTH-1:0] load_pos,
    output logic [NUM_ROTORS*WIDTH-1:0] pos,
    output logic                        stepped,
    output logic                        wrap_out
);

    localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MODULUS);

    logic                        step_req_q;
    logic                        step_fire;
    logic [NUM_ROTORS-1:0]       at_notch;
    logic [NUM_ROTORS-1:0]       adv;
    logic [NUM_ROTORS*WIDTH-1:0] step_pos;
    logic [NUM_ROTORS*WIDTH-1:0] load_clean;
    logic                        wrap_next;

    assign step_fire = step_req & ~step_req_q;

    // All carry decisions look only at registered pre-step positions.
    always_comb begin
        at_notch   = '0;
        adv        = '0;
        step_pos   = pos;
        load_clean = '0;
        for (int i = 0; i < NUM_ROTORS; i++) begin
            at_notch[i] = (pos[i*WIDTH +: WIDTH] == NOTCH[i*WIDTH +: WIDTH]);
        end
        adv[0] = 1'b1;
        for (int i = 1; i < NUM_ROTORS; i++) begin
`ifdef ENIGMA_DOUBLE_STEP_EN
            // Pawl rule: a middle rotor on its own notch moves with the rotor above it.
            adv[i] = at_notch[i-1];
            if (i <= NUM_ROTORS - 2) begin
                adv[i] = adv[i] | at_notch[i];
            end
`else
            adv[i] = adv[i-1] & at_notch[i-1];
`endif
        end
        for (int i = 0; i < NUM_ROTORS; i++) begin
            if (adv[i]) begin
                step_pos[i*WIDTH +: WIDTH] = (pos[i*WIDTH +: WIDTH] == MAX_POS) ?
                                             '0 : pos[i*WIDTH +: WIDTH] + 1'b1;
            end
            load_clean[i*WIDTH +: WIDTH] = ({1'b0, load_pos[i*WIDTH +: WIDTH]} >= MOD_W) ?
                                           '0 : load_pos[i*WIDTH +: WIDTH];
        end
        wrap_next = adv[NUM_ROTORS-1] & (pos[(NUM_ROTORS-1)*WIDTH +: WIDTH] == MAX_POS);
    end

    // step_req_q resets high so a key held across reset release does not step.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pos        <= '0;
            stepped    <= 1'b0;
            wrap_out   <= 1'b0;
            step_req_q <= 1'b1;
        end else begin
            step_req_q <= step_req;
            stepped    <= 1'b0;
            wrap_out   <= 1'b0;
            if (load) begin
                pos <= load_clean;
            end else if (step_fire) begin
                pos      <= step_pos;
                stepped  <= 1'b1;
                wrap_out <= wrap_next;
            end
        end
    end

endmodule
